vga_frame_sequencer: RTL and testbench

- Clocked frame-timing stage that sits directly upstream of the glyph renderer. It replaces the renderer's vsync-clocked frame counter with one that is synchronous to the pixel clock.
- It consumes vsync from the timing generator and synchronises the user pause, step and palette pins.
- It produces the animation frame count, a sticky intro-done flag that gates the initial rain drop, and a palette select that only changes at frame boundaries.

---
 rtl/vga_frame_sequencer.sv | 128 ++++++++++++
 tb/tb_vga_frame_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_sequencer.sv
// Pixel-clock frame sequencer: vsync tick detect, frame counter, pause/step, palette latch.
// Ports: clk, reset, vsync, pause_in, step_in, pal_in -> frame, frame_tick, frame_adv, intro_done, palette.
module vga_frame_sequencer #(
  parameter int FRAME_W         = 10,
  parameter int FRAME_DIV       = 1,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
  input  logic               pause_in,
  input  logic               step_in,
  input  logic [1:0]         pal_in,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_tick,
  output logic               frame_adv,
  output logic               intro_done,
  output logic [1:0]         palette
);

  localparam logic       V_ACT  = !SYNC_ACTIVE_LOW;
  localparam logic [3:0] DIV_M1 = 4'(FRAME_DIV - 1);

  logic               r_vsync_q;
  logic               r_pause_s1, r_pause_s2;
  logic               r_step_s1, r_step_s2, r_step_q;
  logic [1:0]         r_pal_s1, r_pal_s2;
  logic [FRAME_W-1:0] r_frame;
  logic [3:0]         r_pre;
  logic               r_pend;
  logic               r_tick;
  logic               r_adv;
  logic               r_intro;
  logic [1:0]         r_palette;

  logic               w_tick;
  logic               w_step_edge;
  logic               w_do_adv;
  logic [FRAME_W-1:0] w_frame_nxt;
  logic [3:0]         w_pre_nxt;
  logic               w_pend_nxt;
  logic               w_intro_nxt;
  logic [1:0]         w_pal_nxt;

  // Tick fires on the trailing edge of the sync pulse.
  assign w_tick      = (r_vsync_q == V_ACT) && (vsync != V_ACT);
  assign w_step_edge = r_step_s2 & ~r_step_q;

  always_comb begin
    w_frame_nxt = r_frame;
    w_pre_nxt   = r_pre;
    w_intro_nxt = r_intro;
    w_pal_nxt   = r_palette;
    w_pend_nxt  = r_pend | w_step_edge;
    w_do_adv    = 1'b0;
    if (w_tick) begin
      w_pal_nxt = r_pal_s2;
      if (!r_pause_s2) begin
        // A step requested while running is dropped.
        w_pend_nxt = 1'b0;
        if (r_pre == DIV_M1) begin
          w_do_adv = 1'b1;
        end else begin
          w_pre_nxt = r_pre + 4'd1;
        end
      end else if (r_pend || w_step_edge) begin
        // A step edge coinciding with the tick is consumed here.
        w_do_adv   = 1'b1;
        w_pend_nxt = 1'b0;
      end
      if (w_do_adv) begin
        w_frame_nxt = r_frame + FRAME_W'(1);
        w_pre_nxt   = 4'd0;
        if (&r_frame) begin
          w_intro_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vsync_q  <= !V_ACT;
      r_pause_s1 <= 1'b0;
      r_pause_s2 <= 1'b0;
      r_step_s1  <= 1'b0;
      r_step_s2  <= 1'b0;
      r_step_q   <= 1'b0;
      r_pal_s1   <= 2'd0;
      r_pal_s2   <= 2'd0;
      r_frame    <= '0;
      r_pre      <= 4'd0;
      r_pend     <= 1'b0;
      r_tick     <= 1'b0;
      r_adv      <= 1'b0;
      r_intro    <= 1'b0;
      r_palette  <= 2'd0;
    end else begin
      r_vsync_q  <= vsync;
      r_pause_s1 <= pause_in;
      r_pause_s2 <= r_pause_s1;
      r_step_s1  <= step_in;
      r_step_s2  <= r_step_s1;
      r_step_q   <= r_step_s2;
      r_pal_s1   <= pal_in;
      r_pal_s2   <= r_pal_s1;
      r_frame    <= w_frame_nxt;
      r_pre      <= w_pre_nxt;
      r_pend     <= w_pend_nxt;
      r_tick     <= w_tick;
      r_adv      <= w_do_adv;
      r_intro    <= w_intro_nxt;
      r_palette  <= w_pal_nxt;
    end
  end

  always @(posedge clk) begin
    assert (FRAME_DIV >= 1 && FRAME_DIV <= 15)
      else $error("vga_frame_sequencer: FRAME_DIV %0d out of range 1..15", FRAME_DIV);
  end

  assign frame      = r_frame;
  assign frame_tick = r_tick;
  assign frame_adv  = r_adv;
  assign intro_done = r_intro;
  assign palette    = r_palette;

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Directed bench for vga_frame_sequencer (FRAME_DIV=1 and FRAME_DIV=3 instances).
// Compressed frame: vsync low 2 cycles, high 6 cycles.
module tb_vga_frame_sequencer;

  logic       clk = 1'b0;
  logic       reset, vsync, pause_in, step_in;
  logic [1:0] pal_in;

  logic [9:0] frame, d3_frame;
  logic       frame_tick, frame_adv, intro_done;
  logic       d3_tick, d3_adv, d3_intro;
  logic [1:0] palette, d3_pal;

  int n_chk = 0, n_err = 0;
  int idx, n_tick, n_adv, tick_pos, n_tick3, n_adv3, n_stray = 0;
  logic [9:0] tick_frame;
  logic       tick_intro;

  always #5 clk = ~clk;

  vga_frame_sequencer #(.FRAME_W(10), .FRAME_DIV(1), .SYNC_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .pause_in(pause_in),
    .step_in(step_in), .pal_in(pal_in), .frame(frame),
    .frame_tick(frame_tick), .frame_adv(frame_adv),
    .intro_done(intro_done), .palette(palette));

  vga_frame_sequencer #(.FRAME_W(10), .FRAME_DIV(3), .SYNC_ACTIVE_LOW(1)) dut3 (
    .clk(clk), .reset(reset), .vsync(vsync), .pause_in(pause_in),
    .step_in(step_in), .pal_in(pal_in), .frame(d3_frame),
    .frame_tick(d3_tick), .frame_adv(d3_adv),
    .intro_done(d3_intro), .palette(d3_pal));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idx++;
    if (frame_tick) begin
      n_tick++;
      tick_pos   = idx;
      tick_frame = frame;
      tick_intro = intro_done;
    end
    if (frame_adv) n_adv++;
    if (frame_adv && !frame_tick) n_stray++;
    if (d3_tick) n_tick3++;
    if (d3_adv) n_adv3++;
    if (d3_adv && !d3_tick) n_stray++;
  endtask

  task automatic do_frame(input logic stp);
    idx = 0; n_tick = 0; n_adv = 0; tick_pos = -1;
    n_tick3 = 0; n_adv3 = 0;
    vsync = 1'b0;
    if (stp) step_in = 1'b1;
    cyc();
    cyc();
    vsync = 1'b1;
    cyc();
    step_in = 1'b0;
    repeat (5) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vsync = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b1; pause_in = 1'b0;
    step_in = 1'b0; pal_in = 2'd0;
    repeat (3) cyc();
    chk("rst_frame", frame, 0);
    chk("rst_tick", frame_tick, 0);
    chk("rst_adv", frame_adv, 0);
    chk("rst_intro", intro_done, 0);
    chk("rst_pal", palette, 0);
    chk("rst_d3_frame", d3_frame, 0);
    reset = 1'b0;
    cyc();
    chk("post_rst_notick", frame_tick, 0);
    cyc();
    chk("post_rst_frame", frame, 0);

    for (int i = 1; i <= 5; i++) begin
      do_frame(1'b0);
      chk("run_frame", frame, i);
      chk("run_ticks", n_tick, 1);
      chk("run_advs", n_adv, 1);
      chk("run_tick_pos", tick_pos, 3);
      chk("run_intro", intro_done, 0);
    end

    pause_in = 1'b1;
    repeat (3) cyc();
    for (int i = 0; i < 4; i++) begin
      do_frame(1'b0);
      chk("pause_frame", frame, 5);
      chk("pause_adv", n_adv, 0);
      chk("pause_tick", n_tick, 1);
    end

    pal_in = 2'd2;
    repeat (4) cyc();
    chk("pal_hold", palette, 0);
    do_frame(1'b0);
    chk("pal_paused_latch", palette, 2);
    chk("pal_paused_frame", frame, 5);

    step_in = 1'b1;
    cyc();
    cyc();
    step_in = 1'b0;
    repeat (4) cyc();
    chk("step_wait", frame, 5);
    do_frame(1'b0);
    chk("step_frame", frame, 6);
    chk("step_adv", n_adv, 1);
    do_frame(1'b0);
    chk("step_once", frame, 6);
    chk("step_once_adv", n_adv, 0);

    do_frame(1'b1);
    chk("step_at_tick", frame, 7);
    chk("step_at_tick_adv", n_adv, 1);
    do_frame(1'b0);
    chk("step_consumed", frame, 7);

    pause_in = 1'b0;
    repeat (3) cyc();
    do_frame(1'b0);
    chk("resume_frame", frame, 8);
    pal_in = 2'd1;
    repeat (4) cyc();
    chk("pal_run_hold", palette, 2);
    do_frame(1'b0);
    chk("pal_run_latch", palette, 1);
    chk("pal_run_frame", frame, 9);

    do_reset();
    for (int i = 0; i < 1023; i++) do_frame(1'b0);
    chk("pre_wrap_frame", frame, 1023);
    chk("pre_wrap_intro", intro_done, 0);
    do_frame(1'b0);
    chk("wrap_frame", tick_frame, 0);
    chk("wrap_intro_edge", tick_intro, 1);
    for (int i = 0; i < 10; i++) do_frame(1'b0);
    chk("post_wrap_frame", frame, 10);
    chk("post_wrap_intro", intro_done, 1);
    for (int i = 0; i < 490; i++) do_frame(1'b0);
    chk("f500", frame, 500);

    vsync = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    chk("mid_rst_frame", frame, 0);
    chk("mid_rst_intro", intro_done, 0);
    chk("mid_rst_pal", palette, 0);
    chk("mid_rst_tick", frame_tick, 0);
    vsync = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    chk("mid_rst_notick", frame_tick, 0);
    chk("mid_rst_frame2", frame, 0);
    do_frame(1'b0);
    chk("mid_rst_restart", frame, 1);

    do_reset();
    for (int i = 1; i <= 9; i++) begin
      do_frame(1'b0);
      chk("div3_tick", n_tick3, 1);
      chk("div3_adv", n_adv3, (i % 3 == 0) ? 1 : 0);
    end
    chk("div3_frame", d3_frame, 3);

    chk("adv_outside_tick", n_stray, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
